posit_mult_sched: RTL and testbench

POSIT_MULT_SCHED -- requirements
Module: posit_mult_sched

---
 rtl/posit_mult_sched_if.sv | 42 ++++
 rtl/posit_mult_sched.sv | 257 +++++++++++++++++++++++++
 tb/tb_posit_mult_sched.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/posit_mult_sched_if.sv
// posit_mult_sched_if -- request/response bundle for the shared posit multiplier.
//
// Parameters:
//   WORD_SIZE  posit word width in bits
//   NREQ       number of requesters
//
// Signals:
//   req_valid/req_ready  per-requester handshake (req_ready is one-hot or zero)
//   req_a/req_b          packed operands, requester i at [i*WORD_SIZE +: WORD_SIZE]
//   rsp_valid/rsp_ready  result handshake
//   rsp_id               index of the requester that owns the result
//   rsp_out              posit product
//   rsp_inf/rsp_zero     NaR / zero flags of the product
//
// Modports: master = requesters + result consumer, slave = scheduler.
interface posit_mult_sched_if #(
  parameter int WORD_SIZE = 32,
  parameter int NREQ      = 4
);
  localparam int ID_W = $clog2(NREQ);

  logic [NREQ-1:0]           req_valid;
  logic [NREQ-1:0]           req_ready;
  logic [NREQ*WORD_SIZE-1:0] req_a;
  logic [NREQ*WORD_SIZE-1:0] req_b;
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [ID_W-1:0]           rsp_id;
  logic [WORD_SIZE-1:0]      rsp_out;
  logic                      rsp_inf;
  logic                      rsp_zero;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_out, rsp_inf, rsp_zero
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_out, rsp_inf, rsp_zero
  );
endinterface

// File: rtl/posit_mult_sched.sv
// posit_mult_sched -- round-robin scheduler sharing one posit multiplier
// among NREQ requesters.
//
// Parameters: WORD_SIZE (posit width), ES (exponent field width, >= 1),
//             NREQ (requesters, 2..8).
// Ports:
//   clk       sole clock, rising edge
//   rst       asynchronous active-high reset
//   bus       posit_mult_sched_if.slave request/response bundle
//   busy      high whenever the FSM is not IDLE
//   op_count  completed-handshake counter
//
// Optional feature macro: POSIT_MULT_SCHED_OPCOUNT_EN
//   defined   -> op_count counts rsp_valid&rsp_ready handshakes, saturating
//   undefined -> op_count is tied to zero and no counter register exists
//
// posit_mult_sched_mul is the combinational posit multiplier (round to
// nearest even, saturating to maxpos/minpos, never rounding to zero/NaR).

module posit_mult_sched_mul #(
  parameter int N  = 32,
  parameter int ES = 2
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] out,
  output logic         inf,
  output logic         zero
);
  localparam int M  = N - ES;           // mantissa width incl. hidden bit
  localparam int FP = 2 * M - 1;        // product fraction bits after normalising
  localparam int BW = 2 + ES + FP;      // regime seed + exponent + fraction
  localparam int XW = BW + N;           // room so right shifts never lose sticky bits
  localparam int SW = $clog2(N) + ES + 3;
  localparam logic [N-1:0] NAR = {1'b1, {(N-1){1'b0}}};

  logic signed [SW-1:0] scale_a, scale_b, scale_p;
  logic [M-1:0]         mant_a, mant_b;
  logic [2*M-1:0]       prod;
  logic [FP-1:0]        frac;
  logic [BW-1:0]        base;
  logic [XW-1:0]        ext;
  logic [N-2:0]         body_r;
  logic [N-1:0]         res;
  logic                 guard, sticky;
  int                   k, sh;

  // Turn a non-special posit into a signed scale (regime*2^ES + exponent)
  // and a mantissa with the hidden one.
  function automatic void decode(input logic [N-1:0] x,
                                 output logic signed [SW-1:0] scale,
                                 output logic [M-1:0] mant);
    logic [N-2:0] body, sh_body;
    logic         r0;
    logic         run;
    int           m, kd;
    body = x[N-1] ? (~x[N-2:0] + 1'b1) : x[N-2:0];
    r0   = body[N-2];
    m    = 0;
    run  = 1'b1;
    for (int i = N - 2; i >= 0; i--) begin
      if (run && (body[i] == r0)) m++;
      else run = 1'b0;
    end
    sh_body = body << (m + 1);
    kd      = r0 ? (m - 1) : -m;
    scale   = SW'(kd * (1 << ES) + int'(sh_body[N-2 -: ES]));
    mant    = {1'b1, sh_body[N-2-ES:0]};
  endfunction

  always_comb begin
    decode(a, scale_a, mant_a);
    decode(b, scale_b, mant_b);
    prod    = (2*M)'(mant_a) * (2*M)'(mant_b);
    scale_p = scale_a + scale_b;
    // Product of two [1,2) mantissas lies in [1,4); renormalise when >= 2.
    if (prod[2*M-1]) begin
      scale_p = scale_p + SW'(1);
      frac    = prod[2*M-2:0];
    end else begin
      frac    = {prod[2*M-3:0], 1'b0};
    end
    k      = int'(scale_p >>> ES);
    sh     = 0;
    base   = '0;
    ext    = '0;
    guard  = 1'b0;
    sticky = 1'b0;
    if (k > N - 2) begin
      body_r = '1;
    end else if (k < 2 - N) begin
      body_r = (N-1)'(1);
    end else begin
      // Seed "10" (k>=0) or "01" (k<0) and arithmetic-shift so the leading
      // bit replicates into the regime run followed by its terminator.
      base   = (k >= 0) ? {2'b10, scale_p[ES-1:0], frac} : {2'b01, scale_p[ES-1:0], frac};
      sh     = (k >= 0) ? k : (-k - 1);
      ext    = $signed({base, {N{1'b0}}}) >>> sh;
      body_r = ext[XW-1 -: N-1];
      guard  = ext[XW-N];
      sticky = |ext[XW-N-1:0];
      if (guard && (sticky || body_r[0]) && !(&body_r)) body_r = body_r + 1'b1;
    end
    res = {1'b0, body_r};
    if (a[N-1] ^ b[N-1]) res = ~res + 1'b1;
    out  = res;
    inf  = 1'b0;
    zero = 1'b0;
    if (a == NAR || b == NAR) begin
      out = NAR;
      inf = 1'b1;
    end else if (a == '0 || b == '0) begin
      out  = '0;
      zero = 1'b1;
    end
  end
endmodule

module posit_mult_sched #(
  parameter int WORD_SIZE = 32,
  parameter int ES        = 2,
  parameter int NREQ      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  posit_mult_sched_if.slave    bus,
  output logic                 busy,
  output logic [15:0]          op_count
);
  localparam int ID_W = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t               state_q, state_d;
  logic [ID_W-1:0]      ptr_q, ptr_d, id_q, id_d, rsp_id_q, rsp_id_d;
  logic [WORD_SIZE-1:0] a_q, a_d, b_q, b_d, rsp_out_q, rsp_out_d;
  logic                 rsp_inf_q, rsp_inf_d, rsp_zero_q, rsp_zero_d;
  logic                 accept_ok, found, grant;
  logic [ID_W-1:0]      winner;
  logic [NREQ-1:0]      ready;
  logic [WORD_SIZE-1:0] mul_out;
  logic                 mul_inf, mul_zero;
  int                   rr_idx;

  // The single multiplier shared by every requester; it only ever sees the
  // operands latched at accept time.
  posit_mult_sched_mul #(.N(WORD_SIZE), .ES(ES)) u_mul (
    .a    (a_q),
    .b    (b_q),
    .out  (mul_out),
    .inf  (mul_inf),
    .zero (mul_zero)
  );

  // Round-robin search starting at ptr; the grant is combinational and is
  // suppressed while the FSM cannot take a new operation or reset is high.
  always_comb begin
    accept_ok = (state_q == IDLE) || ((state_q == RESP) && bus.rsp_ready);
    found     = 1'b0;
    winner    = '0;
    rr_idx    = 0;
    for (int i = 0; i < NREQ; i++) begin
      rr_idx = (int'(ptr_q) + i) % NREQ;
      if (!found && bus.req_valid[rr_idx]) begin
        found  = 1'b1;
        winner = ID_W'(rr_idx);
      end
    end
    grant = found && accept_ok && !rst;
    ready = grant ? (NREQ'(1) << winner) : '0;
  end

  // FSM next state: accept -> CALC (capture product) -> RESP (hold until
  // consumed), with back-to-back accept from RESP.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    id_d       = id_q;
    a_d        = a_q;
    b_d        = b_q;
    rsp_id_d   = rsp_id_q;
    rsp_out_d  = rsp_out_q;
    rsp_inf_d  = rsp_inf_q;
    rsp_zero_d = rsp_zero_q;
    case (state_q)
      IDLE: if (grant) state_d = CALC;
      CALC: begin
        rsp_out_d  = mul_out;
        rsp_inf_d  = mul_inf;
        rsp_zero_d = mul_zero;
        rsp_id_d   = id_q;
        state_d    = RESP;
      end
      RESP: if (bus.rsp_ready) state_d = grant ? CALC : IDLE;
      default: state_d = IDLE;
    endcase
    if (grant) begin
      a_d   = bus.req_a[int'(winner)*WORD_SIZE +: WORD_SIZE];
      b_d   = bus.req_b[int'(winner)*WORD_SIZE +: WORD_SIZE];
      id_d  = winner;
      ptr_d = ID_W'((int'(winner) + 1) % NREQ);
    end
  end

  // State registers; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      id_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_id_q   <= '0;
      rsp_out_q  <= '0;
      rsp_inf_q  <= 1'b0;
      rsp_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      id_q       <= id_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rsp_id_q   <= rsp_id_d;
      rsp_out_q  <= rsp_out_d;
      rsp_inf_q  <= rsp_inf_d;
      rsp_zero_q <= rsp_zero_d;
    end
  end

  assign bus.req_ready = ready;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_out   = rsp_out_q;
  assign bus.rsp_inf   = rsp_inf_q;
  assign bus.rsp_zero  = rsp_zero_q;
  assign busy          = (state_q != IDLE);

`ifdef POSIT_MULT_SCHED_OPCOUNT_EN
  logic [15:0] op_count_q, op_count_d;

  // Count completed result handshakes, sticking at all-ones.
  always_comb begin
    op_count_d = op_count_q;
    if ((state_q == RESP) && bus.rsp_ready && (op_count_q != 16'hFFFF))
      op_count_d = op_count_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) op_count_q <= '0;
    else     op_count_q <= op_count_d;
  end

  assign op_count = op_count_q;
`else
  assign op_count = '0;
`endif
endmodule

// File: tb/tb_posit_mult_sched.sv
// tb_posit_mult_sched -- directed bench for posit_mult_sched.
// Stimulus pushes hand-computed expected results into a scoreboard queue;
// a monitor pops and compares on every rsp_valid&rsp_ready handshake.
// Inputs are driven 1 time unit after the rising edge, outputs sampled on
// the falling edge.
module tb_posit_mult_sched;
  localparam int W  = 32;
  localparam int NR = 4;

`ifdef POSIT_MULT_SCHED_OPCOUNT_EN
  localparam logic [15:0] EXP_OPS = 16'd3;
`else
  localparam logic [15:0] EXP_OPS = 16'd0;
`endif

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] out;
    logic        inf;
    logic        zero;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        busy;
  logic [15:0] op_count;
  rsp_t        exp_q[$];
  rsp_t        mon_e;
  int          n_cmp  = 0;
  int          n_fail = 0;
  int          order3[5] = '{0, 1, 2, 3, 0};
  int          order7[3] = '{1, 2, 1};

  posit_mult_sched_if #(.WORD_SIZE(W), .NREQ(NR)) bus ();

  posit_mult_sched #(.WORD_SIZE(W), .ES(2), .NREQ(NR)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .busy     (busy),
    .op_count (op_count)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // One comparison: bump the counters and report a mismatch.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic setOperands(input int idx, input logic [31:0] a, input logic [31:0] b);
    bus.req_a[idx*W +: W] = a;
    bus.req_b[idx*W +: W] = b;
  endtask

  task automatic pushExpected(input int id, input logic [31:0] o, input logic inf, input logic zero);
    rsp_t e;
    e.id   = 2'(id);
    e.out  = o;
    e.inf  = inf;
    e.zero = zero;
    exp_q.push_back(e);
  endtask

  task automatic resetDut();
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Wait (bounded) until the FSM is back in IDLE, then align to edge+1.
  task automatic waitIdle(input string name);
    bit done = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (!busy) done = 1;
    end
    if (!done) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL %s_idle_timeout: actual=busy required=idle", name);
    end
    nextCycle();
  endtask

  // Single-requester operation: raise valid, wait for its grant, drop valid.
  task automatic applyStimulus(input string name, input int idx, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] o,
                               input logic inf, input logic zero);
    bit got = 0;
    logic [3:0] one;
    one = 4'b0001 << idx;
    bus.rsp_ready = 1'b1;
    setOperands(idx, a, b);
    pushExpected(idx, o, inf, zero);
    bus.req_valid = one;
    for (int c = 0; c < 10 && !got; c++) begin
      @(negedge clk);
      if (bus.req_ready != 4'b0000) begin
        got = 1;
        checkOutput({name, "_grant"}, 32'(bus.req_ready), 32'(one));
      end
      nextCycle();
    end
    if (!got) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL %s_grant_timeout: actual=none required=%b", name, one);
    end
    bus.req_valid = '0;
    waitIdle(name);
  endtask

  // Scoreboard monitor: every accepted result must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL unexpected_rsp: actual id=%0d out=%h required no response",
                 bus.rsp_id, bus.rsp_out);
      end else begin
        mon_e = exp_q.pop_front();
        checkOutput("rsp_id",   32'(bus.rsp_id),   32'(mon_e.id));
        checkOutput("rsp_out",  bus.rsp_out,       mon_e.out);
        checkOutput("rsp_inf",  32'(bus.rsp_inf),  32'(mon_e.inf));
        checkOutput("rsp_zero", 32'(bus.rsp_zero), 32'(mon_e.zero));
      end
    end
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    n_fail++;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence.
  initial begin
    logic [3:0] one;
    rst           = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    #1 rst = 1'b1;

    // Reset state, with every requester asking.
    bus.req_valid = 4'b1111;
    @(negedge clk);
    checkOutput("rst_req_ready", 32'(bus.req_ready), 32'h0);
    checkOutput("rst_busy",      32'(busy),          32'h0);
    checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    checkOutput("rst_rsp_out",   bus.rsp_out,        32'h0);
    checkOutput("rst_op_count",  32'(op_count),      32'h0);
    bus.req_valid = '0;
    @(posedge clk);
    #1 rst = 1'b0;

    // Single request 1.0 * 2.0 with latency and operand-isolation checks.
    bus.rsp_ready = 1'b1;
    setOperands(0, 32'h40000000, 32'h48000000);
    pushExpected(0, 32'h48000000, 1'b0, 1'b0);
    bus.req_valid = 4'b0001;
    @(negedge clk);
    checkOutput("single_grant", 32'(bus.req_ready), 32'h1);
    nextCycle();
    bus.req_valid = '0;
    setOperands(0, 32'h7FFFFFFF, 32'h7FFFFFFF);
    @(negedge clk);
    checkOutput("single_calc_valid", 32'(bus.rsp_valid), 32'h0);
    checkOutput("single_calc_busy",  32'(busy),          32'h1);
    nextCycle();
    @(negedge clk);
    checkOutput("single_resp_valid", 32'(bus.rsp_valid), 32'h1);
    nextCycle();
    @(negedge clk);
    checkOutput("single_idle_busy", 32'(busy),   32'h0);
    checkOutput("single_hold_out",  bus.rsp_out, 32'h48000000);
    nextCycle();

    // All four requesters continuously valid: grants 0,1,2,3,0 every 2 cycles.
    resetDut();
    setOperands(0, 32'h44000000, 32'h44000000);
    setOperands(1, 32'hC0000000, 32'h48000000);
    setOperands(2, 32'h38000000, 32'h38000000);
    setOperands(3, 32'h4C000000, 32'h4C000000);
    pushExpected(0, 32'h49000000, 1'b0, 1'b0);
    pushExpected(1, 32'hB8000000, 1'b0, 1'b0);
    pushExpected(2, 32'h30000000, 1'b0, 1'b0);
    pushExpected(3, 32'h59000000, 1'b0, 1'b0);
    pushExpected(0, 32'h49000000, 1'b0, 1'b0);
    bus.req_valid = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      one = (c % 2 == 0) ? (4'b0001 << order3[c/2]) : 4'b0000;
      checkOutput("rr_grant", 32'(bus.req_ready), 32'(one));
      nextCycle();
    end
    bus.req_valid = '0;
    waitIdle("rr");

    // Backpressure: 5 stalled RESP cycles, then same-cycle grant of requester 0.
    bus.rsp_ready = 1'b0;
    setOperands(2, 32'h50000000, 32'h50000000);
    setOperands(0, 32'h20000000, 32'h20000000);
    pushExpected(2, 32'h60000000, 1'b0, 1'b0);
    pushExpected(0, 32'h10000000, 1'b0, 1'b0);
    bus.req_valid = 4'b0101;
    @(negedge clk);
    checkOutput("bp_grant2", 32'(bus.req_ready), 32'h4);
    nextCycle();
    bus.req_valid = 4'b0001;
    @(negedge clk);
    checkOutput("bp_calc_ready", 32'(bus.req_ready), 32'h0);
    for (int c = 0; c < 5; c++) begin
      nextCycle();
      @(negedge clk);
      checkOutput("bp_valid", 32'(bus.rsp_valid), 32'h1);
      checkOutput("bp_out",   bus.rsp_out,        32'h60000000);
      checkOutput("bp_id",    32'(bus.rsp_id),    32'h2);
      checkOutput("bp_ready", 32'(bus.req_ready), 32'h0);
    end
    nextCycle();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_grant0", 32'(bus.req_ready), 32'h1);
    nextCycle();
    bus.req_valid = '0;
    waitIdle("bp");

    // Special values and saturation.
    applyStimulus("nar",    1, 32'h80000000, 32'h40000000, 32'h80000000, 1'b1, 1'b0);
    applyStimulus("zero",   3, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b1);
    applyStimulus("maxpos", 2, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b0);
    applyStimulus("minpos", 0, 32'h00000001, 32'h00000001, 32'h00000001, 1'b0, 1'b0);
    applyStimulus("neg",    1, 32'h40000000, 32'hC0000000, 32'hC0000000, 1'b0, 1'b0);
    applyStimulus("nar0",   2, 32'h00000000, 32'h80000000, 32'h80000000, 1'b1, 1'b0);

    // Asynchronous reset in the middle of CALC; the op is dropped.
    setOperands(1, 32'h48000000, 32'h48000000);
    bus.req_valid = 4'b0010;
    @(negedge clk);
    checkOutput("ar_grant", 32'(bus.req_ready), 32'h2);
    nextCycle();
    bus.req_valid = 4'b1111;
    #2 rst = 1'b1;
    #1;
    checkOutput("ar_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    checkOutput("ar_busy",      32'(busy),          32'h0);
    checkOutput("ar_rsp_out",   bus.rsp_out,        32'h0);
    checkOutput("ar_rsp_inf",   32'(bus.rsp_inf),   32'h0);
    checkOutput("ar_rsp_id",    32'(bus.rsp_id),    32'h0);
    checkOutput("ar_req_ready", 32'(bus.req_ready), 32'h0);
    checkOutput("ar_op_count",  32'(op_count),      32'h0);
    bus.req_valid = '0;
    @(posedge clk);
    #1 rst = 1'b0;

    // Valid withdrawn before the edge: no grant, pointer stays at 0.
    bus.req_valid = 4'b0010;
    #2 bus.req_valid = '0;
    nextCycle();
    @(negedge clk);
    checkOutput("withdraw_busy", 32'(busy), 32'h0);
    nextCycle();

    // Three back-to-back ops from requesters 1 and 2: grants 1,2,1.
    setOperands(1, 32'h48000000, 32'h48000000);
    setOperands(2, 32'h40000000, 32'h20000000);
    pushExpected(1, 32'h50000000, 1'b0, 1'b0);
    pushExpected(2, 32'h20000000, 1'b0, 1'b0);
    pushExpected(1, 32'h50000000, 1'b0, 1'b0);
    bus.req_valid = 4'b0110;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      one = (c % 2 == 0) ? (4'b0001 << order7[c/2]) : 4'b0000;
      checkOutput("post_rst_grant", 32'(bus.req_ready), 32'(one));
      nextCycle();
    end
    bus.req_valid = '0;
    waitIdle("post_rst");
    checkOutput("op_count", 32'(op_count), 32'(EXP_OPS));

    checkOutput("scoreboard_left", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
